// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the two-requester RAM arbiter.
// The optional performance counters are enabled with the RAM_ARB_PERF_EN macro.
package ram_arb_pkg;

  typedef enum logic {REQ_A, REQ_B} req_id_t;
  typedef enum logic {OP_READ, OP_WRITE} op_t;

  localparam int PERF_CNT_WIDTH = 16;

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [PERF_CNT_WIDTH-1:0] sat_inc(input logic [PERF_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-requester round-robin grant with its priority pointer.
// The grant is combinational; the pointer moves to the loser after every grant.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  input  logic       b_valid,
  output logic [1:0] grant,
  output req_id_t    grant_id
);

  req_id_t rr_ptr;

  always_comb begin
    grant    = 2'b00;
    grant_id = REQ_A;
    if (!rst) begin
      if (a_valid && b_valid) begin
        grant_id = rr_ptr;
        grant    = (rr_ptr == REQ_A) ? 2'b01 : 2'b10;
      end else if (a_valid) begin
        grant_id = REQ_A;
        grant    = 2'b01;
      end else if (b_valid) begin
        grant_id = REQ_B;
        grant    = 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= REQ_A;
    end else if (|grant) begin
      rr_ptr <= (grant_id == REQ_A) ? REQ_B : REQ_A;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between requesters A and B.
// Define RAM_ARB_PERF_EN to add saturating grant/conflict counters.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_write,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0] a_req_wdata,
  output logic                  a_rsp_valid,
  output logic [DATA_WIDTH-1:0] a_rsp_rdata,

  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic                  b_req_write,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  input  logic [DATA_WIDTH-1:0] b_req_wdata,
  output logic                  b_rsp_valid,
  output logic [DATA_WIDTH-1:0] b_rsp_rdata,

`ifdef RAM_ARB_PERF_EN
  output logic [PERF_CNT_WIDTH-1:0] perf_a_grants,
  output logic [PERF_CNT_WIDTH-1:0] perf_b_grants,
  output logic [PERF_CNT_WIDTH-1:0] perf_conflicts,
`endif

  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_read_enable,
  output logic                  ram_write_enable,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  logic [1:0] grant;
  req_id_t    grant_id;
  op_t        grant_op;
  logic       rsp_pending;
  req_id_t    rsp_id;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst      (rst),
    .a_valid  (a_req_valid),
    .b_valid  (b_req_valid),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign a_req_ready = grant[0];
  assign b_req_ready = grant[1];

  always_comb begin
    ram_addr         = '0;
    ram_data_in      = '0;
    ram_read_enable  = 1'b0;
    ram_write_enable = 1'b0;
    grant_op         = OP_READ;
    if (grant[0]) begin
      ram_addr    = a_req_addr;
      ram_data_in = a_req_wdata;
      grant_op    = a_req_write ? OP_WRITE : OP_READ;
    end else if (grant[1]) begin
      ram_addr    = b_req_addr;
      ram_data_in = b_req_wdata;
      grant_op    = b_req_write ? OP_WRITE : OP_READ;
    end
    if (|grant) begin
      ram_write_enable = (grant_op == OP_WRITE);
      ram_read_enable  = (grant_op == OP_READ);
    end
  end

  // The RAM read takes one cycle, so remember who issued the read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_pending <= 1'b0;
      rsp_id      <= REQ_A;
    end else begin
      rsp_pending <= (|grant) && (grant_op == OP_READ);
      if (|grant) begin
        rsp_id <= grant_id;
      end
    end
  end

  // Gating with rst drops a response whose read was accepted just before reset.
  assign a_rsp_valid = !rst && rsp_pending && (rsp_id == REQ_A);
  assign b_rsp_valid = !rst && rsp_pending && (rsp_id == REQ_B);
  assign a_rsp_rdata = a_rsp_valid ? ram_data_out : '0;
  assign b_rsp_rdata = b_rsp_valid ? ram_data_out : '0;

`ifdef RAM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_a_grants  <= '0;
      perf_b_grants  <= '0;
      perf_conflicts <= '0;
    end else begin
      if (grant[0]) begin
        perf_a_grants <= sat_inc(perf_a_grants);
      end
      if (grant[1]) begin
        perf_b_grants <= sat_inc(perf_b_grants);
      end
      if (a_req_valid && b_req_valid) begin
        perf_conflicts <= sat_inc(perf_conflicts);
      end
    end
  end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural single-port RAM.
// Build with RAM_ARB_PERF_EN defined to also check the perf counters.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_req_valid, a_req_ready, a_req_write, a_rsp_valid;
  logic [3:0] a_req_addr;
  logic [7:0] a_req_wdata, a_rsp_rdata;
  logic       b_req_valid, b_req_ready, b_req_write, b_rsp_valid;
  logic [3:0] b_req_addr;
  logic [7:0] b_req_wdata, b_rsp_rdata;
  logic [3:0] ram_addr;
  logic [7:0] ram_data_in, ram_data_out;
  logic       ram_read_enable, ram_write_enable;
`ifdef RAM_ARB_PERF_EN
  logic [15:0] perf_a_grants, perf_b_grants, perf_conflicts;
`endif

  logic [7:0] mem [16];
  int n_checks = 0;
  int n_errors = 0;
  int row_n    = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .a_req_valid      (a_req_valid),
    .a_req_ready      (a_req_ready),
    .a_req_write      (a_req_write),
    .a_req_addr       (a_req_addr),
    .a_req_wdata      (a_req_wdata),
    .a_rsp_valid      (a_rsp_valid),
    .a_rsp_rdata      (a_rsp_rdata),
    .b_req_valid      (b_req_valid),
    .b_req_ready      (b_req_ready),
    .b_req_write      (b_req_write),
    .b_req_addr       (b_req_addr),
    .b_req_wdata      (b_req_wdata),
    .b_rsp_valid      (b_rsp_valid),
    .b_rsp_rdata      (b_rsp_rdata),
`ifdef RAM_ARB_PERF_EN
    .perf_a_grants    (perf_a_grants),
    .perf_b_grants    (perf_b_grants),
    .perf_conflicts   (perf_conflicts),
`endif
    .ram_addr         (ram_addr),
    .ram_data_in      (ram_data_in),
    .ram_read_enable  (ram_read_enable),
    .ram_write_enable (ram_write_enable),
    .ram_data_out     (ram_data_out)
  );

  always @(posedge clk) begin
    if (ram_write_enable) mem[ram_addr] <= ram_data_in;
    if (ram_read_enable)  ram_data_out  <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL row%0d %s: got %0h expected %0h", row_n, tag, got, exp);
    end
  endtask

  // One cycle: drive the request lines, then check grant, RAM drive and the
  // response for the previous cycle's read.
  task automatic row(input logic r,
                     input logic av, input logic aw, input logic [3:0] aa, input logic [7:0] awd,
                     input logic bv, input logic bw, input logic [3:0] ba, input logic [7:0] bwd,
                     input logic ra, input logic rb, input logic va, input logic vb,
                     input logic [7:0] rda, input logic [7:0] rdb);
    logic [3:0] e_addr;
    logic [7:0] e_din;
    logic       e_re, e_we;
    @(posedge clk);
    #1;
    row_n++;
    rst = r;
    a_req_valid = av; a_req_write = aw; a_req_addr = aa; a_req_wdata = awd;
    b_req_valid = bv; b_req_write = bw; b_req_addr = ba; b_req_wdata = bwd;
    e_addr = ra ? aa : (rb ? ba : 4'h0);
    e_din  = ra ? awd : (rb ? bwd : 8'h00);
    e_we   = (ra && aw) || (rb && bw);
    e_re   = (ra && !aw) || (rb && !bw);
    @(negedge clk);
    check("a_req_ready", a_req_ready, ra);
    check("b_req_ready", b_req_ready, rb);
    check("ram_addr", ram_addr, e_addr);
    check("ram_data_in", ram_data_in, e_din);
    check("ram_write_enable", ram_write_enable, e_we);
    check("ram_read_enable", ram_read_enable, e_re);
    check("a_rsp_valid", a_rsp_valid, va);
    check("b_rsp_valid", b_rsp_valid, vb);
    check("a_rsp_rdata", a_rsp_rdata, rda);
    check("b_rsp_rdata", b_rsp_rdata, rdb);
  endtask

  initial begin
    rst = 1'b1;
    a_req_valid = 0; a_req_write = 0; a_req_addr = 0; a_req_wdata = 0;
    b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_wdata = 0;

    //  rst av aw aa    awd     bv bw ba    bwd      ra rb va vb rda     rdb
    // reset with A requesting: nothing granted
    row(1, 1, 0, 4'h0, 8'h00,  0, 0, 4'h0, 8'h00,  0, 0, 0, 0, 8'h00, 8'h00);
    row(1, 1, 0, 4'h0, 8'h00,  0, 0, 4'h0, 8'h00,  0, 0, 0, 0, 8'h00, 8'h00);
    row(1, 1, 0, 4'h0, 8'h00,  0, 0, 4'h0, 8'h00,  0, 0, 0, 0, 8'h00, 8'h00);
    row(0, 0, 0, 4'h0, 8'h00,  0, 0, 4'h0, 8'h00,  0, 0, 0, 0, 8'h00, 8'h00);
    // preload addr1 = 11 via A, addr2 = 22 via B
    row(0, 1, 1, 4'h1, 8'h11,  0, 0, 4'h0, 8'h00,  1, 0, 0, 0, 8'h00, 8'h00);
    row(0, 0, 0, 4'h0, 8'h00,  1, 1, 4'h2, 8'h22,  0, 1, 0, 0, 8'h00, 8'h00);
    // A writes addr3 = 5A then reads it back
    row(0, 1, 1, 4'h3, 8'h5A,  0, 0, 4'h0, 8'h00,  1, 0, 0, 0, 8'h00, 8'h00);
    row(0, 1, 0, 4'h3, 8'h00,  0, 0, 4'h0, 8'h00,  1, 0, 0, 0, 8'h00, 8'h00);
    row(0, 0, 0, 4'h0, 8'h00,  0, 0, 4'h0, 8'h00,  0, 0, 1, 0, 8'h5A, 8'h00);
    // B alone for 3 cycles, then contention alternates starting with A
    row(0, 0, 0, 4'h0, 8'h00,  1, 0, 4'h2, 8'h00,  0, 1, 0, 0, 8'h00, 8'h00);
    row(0, 0, 0, 4'h0, 8'h00,  1, 0, 4'h2, 8'h00,  0, 1, 0, 1, 8'h00, 8'h22);
    row(0, 0, 0, 4'h0, 8'h00,  1, 0, 4'h2, 8'h00,  0, 1, 0, 1, 8'h00, 8'h22);
    row(0, 1, 0, 4'h1, 8'h00,  1, 0, 4'h2, 8'h00,  1, 0, 0, 1, 8'h00, 8'h22);
    row(0, 1, 0, 4'h1, 8'h00,  1, 0, 4'h2, 8'h00,  0, 1, 1, 0, 8'h11, 8'h00);
    row(0, 1, 0, 4'h1, 8'h00,  1, 0, 4'h2, 8'h00,  1, 0, 0, 1, 8'h00, 8'h22);
    row(0, 1, 0, 4'h1, 8'h00,  1, 0, 4'h2, 8'h00,  0, 1, 1, 0, 8'h11, 8'h00);
    row(0, 0, 0, 4'h0, 8'h00,  0, 0, 4'h0, 8'h00,  0, 0, 0, 1, 8'h00, 8'h22);
    // read accepted then reset: response dropped, pointer back to A
    row(0, 1, 0, 4'h1, 8'h00,  0, 0, 4'h0, 8'h00,  1, 0, 0, 0, 8'h00, 8'h00);
    row(1, 0, 0, 4'h0, 8'h00,  0, 0, 4'h0, 8'h00,  0, 0, 0, 0, 8'h00, 8'h00);
    row(0, 1, 0, 4'h1, 8'h00,  1, 0, 4'h2, 8'h00,  1, 0, 0, 0, 8'h00, 8'h00);
    row(0, 0, 0, 4'h0, 8'h00,  0, 0, 4'h0, 8'h00,  0, 0, 1, 0, 8'h11, 8'h00);
    // B write then read of the same address returns the new data
    row(0, 0, 0, 4'h0, 8'h00,  1, 1, 4'h2, 8'h3C,  0, 1, 0, 0, 8'h00, 8'h00);
    row(0, 0, 0, 4'h0, 8'h00,  1, 0, 4'h2, 8'h00,  0, 1, 0, 0, 8'h00, 8'h00);
    row(0, 0, 0, 4'h0, 8'h00,  0, 0, 4'h0, 8'h00,  0, 0, 0, 1, 8'h00, 8'h3C);
    // reset, 5 contention cycles, then 2 A-only cycles
    row(1, 0, 0, 4'h0, 8'h00,  0, 0, 4'h0, 8'h00,  0, 0, 0, 0, 8'h00, 8'h00);
    row(0, 1, 0, 4'h1, 8'h00,  1, 0, 4'h2, 8'h00,  1, 0, 0, 0, 8'h00, 8'h00);
    row(0, 1, 0, 4'h1, 8'h00,  1, 0, 4'h2, 8'h00,  0, 1, 1, 0, 8'h11, 8'h00);
    row(0, 1, 0, 4'h1, 8'h00,  1, 0, 4'h2, 8'h00,  1, 0, 0, 1, 8'h00, 8'h3C);
    row(0, 1, 0, 4'h1, 8'h00,  1, 0, 4'h2, 8'h00,  0, 1, 1, 0, 8'h11, 8'h00);
    row(0, 1, 0, 4'h1, 8'h00,  1, 0, 4'h2, 8'h00,  1, 0, 0, 1, 8'h00, 8'h3C);
    row(0, 1, 0, 4'h1, 8'h00,  0, 0, 4'h0, 8'h00,  1, 0, 1, 0, 8'h11, 8'h00);
    row(0, 1, 0, 4'h1, 8'h00,  0, 0, 4'h0, 8'h00,  1, 0, 1, 0, 8'h11, 8'h00);
    row(0, 0, 0, 4'h0, 8'h00,  0, 0, 4'h0, 8'h00,  0, 0, 1, 0, 8'h11, 8'h00);
`ifdef RAM_ARB_PERF_EN
    check("perf_conflicts", perf_conflicts, 32'd5);
    check("perf_a_grants", perf_a_grants, 32'd5);
    check("perf_b_grants", perf_b_grants, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
